// File: rtl/img_loader.sv
// Image loader: packs four 8-bit pixels per 32-bit word, writes WORDS words to memory,
// then kicks the downstream accelerator and reports completion.
module img_loader #(
  parameter int unsigned WORDS     = 25344,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [7:0]  pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [15:0] addr,
  output logic [31:0] dataW,
  output logic        en,
  output logic        we,
  output logic        acc_start,
  input  logic        acc_finish,
  output logic        done
);

  localparam int unsigned CntW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [15:0] BaseAddr = 16'(BASE_ADDR);
  localparam logic [CntW-1:0] LastWord = CntW'(WORDS - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFill    = 3'd1;
  localparam logic [2:0] StWrite   = 3'd2;
  localparam logic [2:0] StKick    = 3'd3;
  localparam logic [2:0] StWaitAcc = 3'd4;
  localparam logic [2:0] StDone    = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [CntW-1:0] word_cnt_q, word_cnt_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [31:0]     pack_q, pack_d;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    byte_cnt_d = byte_cnt_q;
    pack_d     = pack_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          state_d    = StFill;
          word_cnt_d = '0;
          byte_cnt_d = '0;
        end
      end
      StFill: begin
        if (pix_valid) begin
          // First pixel of a word lands in the most significant lane.
          unique case (byte_cnt_q)
            2'd0: pack_d[31:24] = pix_data;
            2'd1: pack_d[23:16] = pix_data;
            2'd2: pack_d[15:8]  = pix_data;
            2'd3: pack_d[7:0]   = pix_data;
            default: pack_d = pack_q;
          endcase
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        if (word_cnt_q == LastWord) begin
          state_d = StKick;
        end else begin
          word_cnt_d = word_cnt_q + 1'b1;
          state_d    = StFill;
        end
      end
      StKick:    state_d = StWaitAcc;
      StWaitAcc: if (acc_finish) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    pix_ready = 1'b0;
    en        = 1'b0;
    we        = 1'b0;
    addr      = '0;
    dataW     = '0;
    acc_start = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      StFill: pix_ready = 1'b1;
      StWrite: begin
        en    = 1'b1;
        we    = 1'b1;
        addr  = BaseAddr + 16'(word_cnt_q);
        dataW = pack_q;
      end
      StKick: acc_start = 1'b1;
      StDone: done      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      pack_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      pack_q     <= pack_d;
    end
  end

endmodule
